// File: rtl/simd_lane_issue_ctrl.sv
// simd_lane_issue_ctrl -- issue control for the SIMD dot-product lanes.
//
// Decoded requests arrive one at a time. A LOAD marks one lane as holding an
// operand and pulses that lane's write-enable. An EXEC checks that every lane
// it needs is loaded, then launches to the datapath, waits ExecLatency cycles
// and pulses done. Requests that cannot be honoured pulse err_o.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   req_valid_i / req_ready_o  request handshake (ready only when idle)
//   req_load_i / req_exec_i    request opcode (exactly one must be set)
//   req_lane_idx_i             target lane of a load
//   req_lane_mask_i            lanes used by an exec (0 = all lanes)
//   req_id_i                   instruction id
//   lane_we_o                  one-hot lane write-enable pulse
//   lane_loaded_o              loaded-lane bitmap
//   exec_valid_o / exec_ready_i launch handshake to the datapath
//   exec_mask_o, exec_id_o     effective mask and id of the launch
//   done_o, done_id_o          completion pulse and its id
//   err_o                      rejected-request pulse
//   busy_o                     controller not idle

// Per-lane state: loaded flag plus the registered write-enable pulse.
// set_i and clr_i never coincide (load only in IDLE, clear only in DONE).
module simd_lane_slot (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic set_i,
  input  logic clr_i,
  output logic we_o,
  output logic loaded_o
);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_o     <= 1'b0;
      loaded_o <= 1'b0;
    end else begin
      we_o <= set_i;
      if (set_i)      loaded_o <= 1'b1;
      else if (clr_i) loaded_o <= 1'b0;
    end
  end
endmodule

module simd_lane_issue_ctrl #(
  parameter int NrLanes     = 8,
  parameter int IdW         = 4,
  parameter int ExecLatency = 2,
  parameter int ClearOnExec = 1,
  localparam int IdxW       = (NrLanes > 1) ? $clog2(NrLanes) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_load_i,
  input  logic               req_exec_i,
  input  logic [IdxW-1:0]    req_lane_idx_i,
  input  logic [NrLanes-1:0] req_lane_mask_i,
  input  logic [IdW-1:0]     req_id_i,
  output logic [NrLanes-1:0] lane_we_o,
  output logic [NrLanes-1:0] lane_loaded_o,
  output logic               exec_valid_o,
  input  logic               exec_ready_i,
  output logic [NrLanes-1:0] exec_mask_o,
  output logic [IdW-1:0]     exec_id_o,
  output logic               done_o,
  output logic [IdW-1:0]     done_id_o,
  output logic               err_o,
  output logic               busy_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] RUN    = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [3:0]    LatM1    = 4'(ExecLatency - 1);
  localparam logic [IdxW:0] NrLanesW = (IdxW + 1)'(NrLanes);

  typedef struct packed {
    logic               load;
    logic               exec;
    logic [IdxW-1:0]    idx;
    logic [NrLanes-1:0] mask;
    logic [IdW-1:0]     id;
  } req_t;

  req_t               req;
  logic [1:0]         state;
  logic [3:0]         cnt;
  logic               accept, op_ok, idx_ok;
  logic               do_load, do_exec, reject, clr_en;
  logic [NrLanes-1:0] eff_mask, missing;

  assign req = '{load: req_load_i, exec: req_exec_i, idx: req_lane_idx_i,
                 mask: req_lane_mask_i, id: req_id_i};

  assign accept   = req_valid_i && (state == IDLE);
  assign op_ok    = req.load ^ req.exec;
  // Index width can exceed the lane count when NrLanes is not a power of 2.
  assign idx_ok   = {1'b0, req.idx} < NrLanesW;
  assign eff_mask = (req.mask == '0) ? '1 : req.mask;
  assign missing  = eff_mask & ~lane_loaded_o;

  assign do_load  = accept && op_ok && req.load && idx_ok;
  assign do_exec  = accept && op_ok && req.exec && (missing == '0);
  assign reject   = accept && !do_load && !do_exec;
  assign clr_en   = (state == DONE) && (ClearOnExec != 0);

  for (genvar i = 0; i < NrLanes; i++) begin : g_lane
    simd_lane_slot u_slot (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .set_i    (do_load && (req.idx == IdxW'(i))),
      .clr_i    (clr_en && exec_mask_o[i]),
      .we_o     (lane_we_o[i]),
      .loaded_o (lane_loaded_o[i])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      cnt         <= '0;
      exec_mask_o <= '0;
      exec_id_o   <= '0;
      err_o       <= 1'b0;
    end else begin
      err_o <= reject;
      case (state)
        IDLE: if (do_exec) begin
          state       <= LAUNCH;
          exec_mask_o <= eff_mask;
          exec_id_o   <= req.id;
        end
        LAUNCH: if (exec_ready_i) begin
          state <= RUN;
          cnt   <= LatM1;
        end
        // cnt runs LatM1..0, giving exactly ExecLatency cycles in RUN.
        RUN: if (cnt == '0) state <= DONE;
             else           cnt   <= cnt - 4'd1;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = (state == IDLE);
  assign busy_o       = (state != IDLE);
  assign exec_valid_o = (state == LAUNCH);
  assign done_o       = (state == DONE);
  assign done_id_o    = done_o ? exec_id_o : '0;

endmodule

// File: tb/tb_simd_lane_issue_ctrl.sv
module tb_simd_lane_issue_ctrl;
  localparam int N = 8, IW = 4, LAT = 2, NB = 6;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance, NrLanes = 8
  logic          req_valid = 0, req_load = 0, req_exec = 0, exec_ready = 1;
  logic [2:0]    req_idx = 0;
  logic [N-1:0]  req_mask = 0;
  logic [IW-1:0] req_id = 0;
  logic          req_ready, exec_valid, done, err, busy;
  logic [N-1:0]  lane_we, lane_loaded, exec_mask;
  logic [IW-1:0] exec_id, done_id;

  simd_lane_issue_ctrl #(.NrLanes(N), .IdW(IW), .ExecLatency(LAT), .ClearOnExec(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_load_i(req_load), .req_exec_i(req_exec), .req_lane_idx_i(req_idx),
    .req_lane_mask_i(req_mask), .req_id_i(req_id), .lane_we_o(lane_we),
    .lane_loaded_o(lane_loaded), .exec_valid_o(exec_valid), .exec_ready_i(exec_ready),
    .exec_mask_o(exec_mask), .exec_id_o(exec_id), .done_o(done), .done_id_o(done_id),
    .err_o(err), .busy_o(busy));

  // second instance, NrLanes = 6 (index width exceeds lane count)
  logic          b_valid = 0, b_load = 0, b_exec = 0;
  logic [2:0]    b_idx = 0;
  logic [NB-1:0] b_mask = 0;
  logic          b_ready, b_exec_valid, b_done, b_err, b_busy;
  logic [NB-1:0] b_we, b_loaded, b_exec_mask;
  logic [IW-1:0] b_exec_id, b_done_id;

  simd_lane_issue_ctrl #(.NrLanes(NB), .IdW(IW), .ExecLatency(LAT), .ClearOnExec(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(b_valid), .req_ready_o(b_ready),
    .req_load_i(b_load), .req_exec_i(b_exec), .req_lane_idx_i(b_idx),
    .req_lane_mask_i(b_mask), .req_id_i(4'd0), .lane_we_o(b_we),
    .lane_loaded_o(b_loaded), .exec_valid_o(b_exec_valid), .exec_ready_i(1'b1),
    .exec_mask_o(b_exec_mask), .exec_id_o(b_exec_id), .done_o(b_done), .done_id_o(b_done_id),
    .err_o(b_err), .busy_o(b_busy));

  int checks = 0, failures = 0;
  logic [N-1:0]  q_we[$];
  logic [IW-1:0] q_done[$];
  int            pending_err = 0;
  logic [N-1:0]  mdl = '0;
  logic [N-1:0]  e_we;
  logic [IW-1:0] e_id;

  // scoreboard monitor: every output pulse must match the next expectation
  always @(negedge clk) if (rst_n) begin
    if (lane_we != '0) begin
      checks++;
      if (q_we.size() == 0) begin
        failures++; $display("FAIL we_unexpected got=%h required=none", lane_we);
      end else begin
        e_we = q_we.pop_front();
        if (lane_we !== e_we) begin
          failures++; $display("FAIL we_onehot got=%h required=%h", lane_we, e_we);
        end
      end
    end
    if (done) begin
      checks++;
      if (q_done.size() == 0) begin
        failures++; $display("FAIL done_unexpected id=%h", done_id);
      end else begin
        e_id = q_done.pop_front();
        if (done_id !== e_id) begin
          failures++; $display("FAIL done_id got=%h required=%h", done_id, e_id);
        end
      end
    end
    if (err) begin
      checks++;
      if (pending_err == 0) begin
        failures++; $display("FAIL err_unexpected got=1 required=0");
      end else pending_err--;
    end
    if (err && lane_we != '0) begin
      checks++; failures++; $display("FAIL err_with_we we=%h", lane_we);
    end
  end

  // drive one request (called at posedge+1) and record its expected effect
  task automatic send(input logic ld, input logic ex, input logic [2:0] idx,
                      input logic [N-1:0] mask, input logic [IW-1:0] id);
    logic [N-1:0] m;
    logic [N-1:0] oh;
    int n = 0;
    while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin
      checks++; failures++; $display("FAIL send_timeout ready=%b required=1", req_ready);
    end
    req_valid = 1; req_load = ld; req_exec = ex; req_idx = idx; req_mask = mask; req_id = id;
    if (ld ^ ex) begin
      if (ld) begin
        oh = '0; oh[idx] = 1'b1;
        q_we.push_back(oh); mdl[idx] = 1'b1;
      end else begin
        m = (mask == '0) ? '1 : mask;
        if ((m & ~mdl) != '0) pending_err++;
        else begin q_done.push_back(id); mdl = mdl & ~m; end
      end
    end else pending_err++;
    @(posedge clk); #1;
    req_valid = 0; req_load = 0; req_exec = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (busy) begin failures++; $display("FAIL idle_timeout busy=%b required=0", busy); end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0; #12;
    checks++;
    if ({req_ready, busy, exec_valid, done, err} !== 5'b10000 || lane_loaded !== '0 ||
        lane_we !== '0 || exec_mask !== '0 || exec_id !== '0 || done_id !== '0) begin
      failures++;
      $display("FAIL reset_state rdy/busy/ev/done/err=%b loaded=%h required=10000 00",
               {req_ready, busy, exec_valid, done, err}, lane_loaded);
    end
    @(posedge clk); #1; rst_n = 1;
    send(1, 0, 3'd0, '0, '0);   // accepted on the first edge after release
  endtask

  task automatic test_load_all();
    for (int i = 1; i < N; i++) send(1, 0, 3'(i), '0, '0);
    send(1, 0, 3'd3, '0, '0);   // reload of a loaded lane
    #10;
    checks++;
    if (lane_loaded !== 8'hFF) begin
      failures++; $display("FAIL load_all loaded=%h required=ff", lane_loaded);
    end
  endtask

  task automatic test_exec_basic();
    exec_ready = 1;
    send(0, 1, '0, 8'h00, 4'd5);
    checks++;
    if (!exec_valid || exec_mask !== 8'hFF || exec_id !== 4'd5 || req_ready || !busy) begin
      failures++; $display("FAIL launch ev=%b mask=%h id=%h rdy=%b required=1 ff 5 0",
                           exec_valid, exec_mask, exec_id, req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (exec_valid || done) begin
      failures++; $display("FAIL run1 ev=%b done=%b required=0 0", exec_valid, done);
    end
    @(posedge clk); #1;
    checks++;
    if (done) begin failures++; $display("FAIL run2 done=%b required=0", done); end
    @(posedge clk); #1;
    checks++;
    if (!done || done_id !== 4'd5) begin
      failures++; $display("FAIL done_latency done=%b id=%h required=1 5", done, done_id);
    end
    @(posedge clk); #1;
    checks++;
    if (done || lane_loaded !== 8'h00 || busy) begin
      failures++; $display("FAIL after_done done=%b loaded=%h required=0 00", done, lane_loaded);
    end
  endtask

  task automatic test_exec_reject();
    for (int i = 0; i < 4; i++) send(1, 0, 3'(i), '0, '0);
    send(0, 1, '0, 8'h30, 4'd2);
    checks++;
    if (!err || exec_valid || busy) begin
      failures++; $display("FAIL exec_reject err=%b ev=%b busy=%b required=1 0 0", err, exec_valid, busy);
    end
    send(0, 1, '0, 8'h00, 4'd3);   // mask 0 means all lanes, 4..7 missing
    send(0, 0, '0, 8'h01, 4'd3);   // neither opcode
    send(1, 1, 3'd2, 8'h01, 4'd3); // both opcodes
    #10;
    checks++;
    if (lane_loaded !== 8'h0F || busy) begin
      failures++; $display("FAIL reject_bitmap loaded=%h required=0f", lane_loaded);
    end
  endtask

  task automatic test_launch_stall();
    exec_ready = 0;
    send(0, 1, '0, 8'h05, 4'd9);
    // a request presented while busy must be ignored
    req_valid = 1; req_load = 1; req_idx = 3'd7;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (!exec_valid || exec_mask !== 8'h05 || exec_id !== 4'd9 || req_ready || lane_loaded !== 8'h0F) begin
        failures++; $display("FAIL stall_c%0d ev=%b mask=%h id=%h rdy=%b loaded=%h required=1 05 9 0 0f",
                             c, exec_valid, exec_mask, exec_id, req_ready, lane_loaded);
      end
      @(posedge clk); #1;
    end
    req_valid = 0; req_load = 0;
    exec_ready = 1;
    checks++;
    if (!exec_valid) begin failures++; $display("FAIL stall_c3 ev=%b required=1", exec_valid); end
    @(posedge clk); #1;
    checks++;
    if (exec_valid || !busy) begin
      failures++; $display("FAIL launched ev=%b busy=%b required=0 1", exec_valid, busy);
    end
    wait_idle();
    checks++;
    if (lane_loaded !== 8'h0A || exec_mask !== 8'h05 || exec_id !== 4'd9) begin
      failures++; $display("FAIL stall_clear loaded=%h mask=%h id=%h required=0a 05 9",
                           lane_loaded, exec_mask, exec_id);
    end
  endtask

  task automatic test_back_to_back();
    send(0, 1, '0, 8'h02, 4'd1);
    send(1, 0, 3'd6, '0, '0);      // waits in send for ready, then loads
    send(0, 1, '0, 8'h48, 4'd14);
    wait_idle();
    checks++;
    if (lane_loaded !== 8'h00) begin
      failures++; $display("FAIL b2b_bitmap loaded=%h required=00", lane_loaded);
    end
  endtask

  task automatic test_bad_req_6lane();
    b_valid = 1; b_load = 1; b_idx = 3'd7;
    @(posedge clk); #1; b_valid = 0;
    checks++;
    if (!b_err || b_we !== '0 || b_loaded !== '0 || b_busy) begin
      failures++; $display("FAIL b_idx7 err=%b we=%h loaded=%h required=1 00 00", b_err, b_we, b_loaded);
    end
    b_valid = 1; b_load = 1; b_exec = 1; b_idx = 3'd1;
    @(posedge clk); #1; b_valid = 0; b_exec = 0;
    checks++;
    if (!b_err || b_we !== '0 || b_loaded !== '0 || b_busy) begin
      failures++; $display("FAIL b_both err=%b we=%h loaded=%h required=1 00 00", b_err, b_we, b_loaded);
    end
    b_valid = 1; b_load = 1; b_idx = 3'd5;
    @(posedge clk); #1; b_valid = 0; b_load = 0;
    checks++;
    if (b_err || b_we !== 6'h20 || b_loaded !== 6'h20) begin
      failures++; $display("FAIL b_lane5 err=%b we=%h loaded=%h required=0 20 20", b_err, b_we, b_loaded);
    end
  endtask

  task automatic test_reset_abort();
    exec_ready = 1;
    for (int i = 0; i < N; i++) send(1, 0, 3'(i), '0, '0);
    send(0, 1, '0, 8'h00, 4'd7);
    @(posedge clk); #3;             // now in RUN
    rst_n = 0; #1;
    q_done.delete(); mdl = '0;
    checks++;
    if ({busy, exec_valid, done, err} !== 4'b0000 || !req_ready || lane_loaded !== '0 ||
        lane_we !== '0 || exec_mask !== '0 || exec_id !== '0 || done_id !== '0) begin
      failures++; $display("FAIL abort busy/ev/done/err=%b rdy=%b loaded=%h required=0000 1 00",
                           {busy, exec_valid, done, err}, req_ready, lane_loaded);
    end
    @(posedge clk); #1; rst_n = 1;
    repeat (8) @(posedge clk); #1;   // monitor flags any stray done
    checks++;
    if (lane_loaded !== '0 || busy) begin
      failures++; $display("FAIL post_abort loaded=%h busy=%b required=00 0", lane_loaded, busy);
    end
  endtask

  initial begin
    test_reset();
    test_load_all();
    test_exec_basic();
    test_exec_reject();
    test_launch_stall();
    test_back_to_back();
    test_bad_req_6lane();
    test_reset_abort();
    repeat (3) @(posedge clk); #1;
    checks++;
    if (q_we.size() != 0 || q_done.size() != 0 || pending_err != 0) begin
      failures++; $display("FAIL scoreboard_drain we=%0d done=%0d err=%0d required=0 0 0",
                           q_we.size(), q_done.size(), pending_err);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
